// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - state_t       : arbiter FSM states (IDLE / OWN / STALL)
//   - DEF_*         : default parameter values for NUM_REQ, DATA_WIDTH, MAX_BURST
//   - idx_width()   : width of an index into a vector of n requesters (min 1)
// Optional feature macro used by the top: FIFO_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no owner
    OWN   = 2'd1,  // owner present, FIFO accepting
    STALL = 2'd2   // owner present, FIFO full
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 4;

  // A single requester still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search. The search starts at
// i_last_owner+1 (mod NUM_REQ) and returns the first requester found.
// Ports:
//   i_req        [NUM_REQ-1:0]  request vector
//   i_last_owner [IW-1:0]       index of the most recently released owner
//   o_winner     [NUM_REQ-1:0]  one-hot winner (all-zero when none)
//   o_valid                     at least one request present
// -----------------------------------------------------------------------------
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW     = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last_owner,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_valid
);

  int w_idx;

  // Walk the candidates in priority order (distance 1..NUM_REQ from the last
  // owner). The inner loop compares against constant positions so no
  // variable bit-select is needed on the vectors.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(i_last_owner) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!o_valid && i_req[i] && (w_idx == i)) begin
          o_winner[i] = 1'b1;
          o_valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one FIFO write port among NUM_REQ requesters. An owner is chosen
// round-robin from IDLE, keeps the port for up to MAX_BURST accepted beats,
// and is released on a dropped request or on its final beat. One IDLE cycle
// always separates two grants.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   req          [NUM_REQ-1:0]          per-requester write request
//   req_data     [NUM_REQ*DATA_WIDTH]   packed data, slice i = requester i
//   full                                FIFO full flag
//   gnt          [NUM_REQ-1:0]          registered one-hot owner
//   wr_en                               FIFO write enable (combinational)
//   data_out     [DATA_WIDTH-1:0]       FIFO write data (0 when no write)
//   busy                                FSM not in IDLE
//   stall_cycles [15:0]                 saturating STALL cycle count, present
//                                       only when FIFO_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_cycles
`endif
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  state_t              r_state, w_state_next;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_next;
  logic [IW-1:0]       r_last_owner, w_last_owner_next;
  logic [CW-1:0]       r_cnt, w_cnt_next, w_cnt_inc;

  logic [NUM_REQ-1:0]  w_pick;
  logic                w_pick_valid;
  logic                w_owner_req;
  logic [IW-1:0]       w_owner_idx;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic                w_accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req        (req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_pick),
    .o_valid      (w_pick_valid)
  );

  // Decode the one-hot owner into its request bit, index and data slice.
  always_comb begin
    w_owner_req  = |(req & r_gnt);
    w_owner_idx  = '0;
    w_owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        w_owner_idx  = IW'(i);
        w_owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A beat is only taken in OWN; STALL never writes even once full falls,
  // and reset suppresses any write in the cycle it is asserted.
  assign w_accept  = (r_state == OWN) && w_owner_req && !full && !rst;
  assign w_cnt_inc = r_cnt + CW'(1);

  assign gnt      = r_gnt;
  assign wr_en    = w_accept;
  assign data_out = w_accept ? w_owner_data : '0;
  assign busy     = (r_state != IDLE) && !rst;

  always_comb begin
    w_state_next      = r_state;
    w_gnt_next        = r_gnt;
    w_cnt_next        = r_cnt;
    w_last_owner_next = r_last_owner;
    case (r_state)
      IDLE: begin
        w_gnt_next = '0;
        if (w_pick_valid) begin
          w_gnt_next   = w_pick;
          w_cnt_next   = '0;
          w_state_next = OWN;
        end
      end
      OWN: begin
        if (!w_owner_req) begin
          w_state_next      = IDLE;
          w_gnt_next        = '0;
          w_last_owner_next = w_owner_idx;
        end else if (full) begin
          w_state_next = STALL;
        end else begin
          w_cnt_next = w_cnt_inc;
          // Final beat of the burst is written this cycle, then released.
          if (w_cnt_inc == MAX_CNT) begin
            w_state_next      = IDLE;
            w_gnt_next        = '0;
            w_last_owner_next = w_owner_idx;
          end
        end
      end
      STALL: begin
        if (!w_owner_req) begin
          w_state_next      = IDLE;
          w_gnt_next        = '0;
          w_last_owner_next = w_owner_idx;
        end else if (!full) begin
          w_state_next = OWN;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_cnt        <= '0;
      // Start the search just past the last index so requester 0 goes first.
      r_last_owner <= IW'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_next;
      r_gnt        <= w_gnt_next;
      r_cnt        <= w_cnt_next;
      r_last_owner <= w_last_owner_next;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if ((r_state == STALL) && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed scenarios plus randomized traffic, every cycle compared against a
// behavioural model of the arbiter (owner index, beat count, stalled flag).
// Optional macro FIFO_ARB_STATS_EN enables the stall_cycles port and checks.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;
`ifdef FIFO_ARB_STATS_EN
  localparam int HOLD = 70000;
`else
  localparam int HOLD = 300;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            full;
  logic [N-1:0]    gnt;
  logic            wr_en;
  logic [DW-1:0]   data_out;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]     stall_cycles;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .data_out (data_out),
    .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_owner;      // -1 when nobody owns the port
  int m_last;
  int m_cnt;
  bit m_stalled;
  int m_stall;

  // Observation bookkeeping
  logic [N-1:0] b_gnt;
  int           b_writes;
  int           w_total;
  int           g_log[$];
  logic [N-1:0] seen_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = N - 1;
    m_cnt     = 0;
    m_stalled = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven: compare, advance
  // the model across the next rising edge, return at the following fall.
  task automatic step();
    logic [N-1:0]  eg;
    logic          ew;
    logic [DW-1:0] ed;
    #1;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    ew = !rst && (m_owner >= 0) && !m_stalled && req[m_owner] && !full;
    ed = ew ? req_data[m_owner*DW +: DW] : '0;
    seen_gnt = gnt;
    chk("gnt", gnt, eg);
    chk("wr_en", wr_en, ew);
    chk("data_out", data_out, ed);
    chk("busy", busy, !rst && (m_owner >= 0));
    chk("no_wr_when_full", wr_en & full, 1'b0);
    chk("gnt_onehot0", $onehot0(gnt), 1'b1);
    if (gnt !== b_gnt) begin
      b_gnt    = gnt;
      b_writes = 0;
      if (gnt != '0) g_log.push_back($clog2(gnt));
    end
    if (wr_en === 1'b1) begin
      b_writes++;
      w_total++;
      $display("WR t=%0t gnt=%b data=%h", $time, gnt, data_out);
    end
    chk("burst_le_max", b_writes <= MB, 1'b1);
`ifdef FIFO_ARB_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
    if (rst) m_stall = 0;
    else if (m_stalled && m_stall < 65535) m_stall++;
`endif
    // Model update
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (m_owner < 0 && req[i]) begin
          m_owner   = i;
          m_cnt     = 0;
          m_stalled = 1'b0;
        end
      end
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_stalled) begin
      m_stalled = full;
    end else if (full) begin
      m_stalled = 1'b1;
    end else begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    req  = '0;
    full = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    full     = 1'b0;
    req_data = '0;
    b_gnt    = '0;
    b_writes = 0;
    w_total  = 0;
    m_stall  = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state observed while reset is still asserted
    step();
    rst = 1'b0;
    step();

    // All four requesting continuously: grants 0,1,2,3,0, four beats each
    g_log.delete();
    w_total = 0;
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      req_data = {$urandom, $urandom};
      step();
    end
    chk("rr_grant_count", g_log.size(), 5);
    for (int g = 0; g < 5 && g < g_log.size(); g++) begin
      chk("rr_grant_order", g_log[g], g % N);
    end
    chk("rr_total_writes", w_total, 20);
    drain();

    // Single requester with a 3-cycle full window after two beats
    w_total  = 0;
    req      = 4'b0100;
    req_data = {4{16'hA5A5}};
    step();                       // IDLE, grant picked
    step();                       // beat 1
    step();                       // beat 2
    full = 1'b1;
    repeat (3) step();
    chk("stall_gnt_held", seen_gnt, 4'b0100);
    full = 1'b0;
    repeat (4) step();            // resume, beats 3 and 4, release
    chk("stall_total_writes", w_total, 4);
    drain();

    // Owner drops request after one beat while another is waiting
    req = 4'b0010; req_data = {$urandom, $urandom};
    step();
    req = 4'b1010;
    step();                       // beat 1 of requester 1
    req = 4'b1000;
    step();                       // requester 1 gone: release, no write
    step();
    chk("drop_idle_bubble", seen_gnt, 4'b0000);
    step();
    chk("drop_next_owner", seen_gnt, 4'b1000);
    drain();

    // Reset in the middle of a burst
    req = 4'b0010; req_data = {$urandom, $urandom};
    step();
    step();                       // beat 1
    rst = 1'b1;
    step();                       // would be beat 2, suppressed
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("rst_gnt_cleared", seen_gnt, 4'b0000);
    step();
    chk("rst_first_grant", seen_gnt, 4'b0001);
    drain();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req      = 4'($urandom);
      full     = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      req_data = {$urandom, $urandom};
      step();
    end
    rst = 1'b0;
    drain();

    // Long stall with the owner holding its request
    rst = 1'b1;
    step();
    rst = 1'b0;
    w_total = 0;
    req = 4'b0001;
    step();
    full = 1'b1;
    repeat (HOLD) step();
    chk("long_stall_no_writes", w_total, 0);
`ifdef FIFO_ARB_STATS_EN
    chk("stall_saturated", stall_cycles, 16'hFFFF);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port.
REQ-002 Parameter DATA_WIDTH, default 16: width of each requester's data word.
REQ-003 Parameter MAX_BURST, default 4: maximum beats accepted per grant.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester write request; requester holds it high while its data is valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed data; slice i belongs to requester i.
REQ-008 full  input  1  FIFO full flag.
REQ-009 gnt  output  NUM_REQ  registered one-hot current owner; all-zero when no owner.
REQ-010 wr_en  output  1  FIFO write enable.
REQ-011 data_out  output  DATA_WIDTH  FIFO write data.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE (no owner), OWN (owner, FIFO not full), STALL (owner, FIFO full).
REQ-014 IDLE: if any req bit is high, pick a winner round-robin, starting the search at last_owner+1 modulo NUM_REQ; gnt goes one-hot next cycle; state goes to OWN.
REQ-015 IDLE with req all-zero: stay in IDLE, gnt=0.
REQ-016 Beat accept: wr_en = owner's req & !full, combinational in the same cycle; data_out = owner's req_data slice.
REQ-017 wr_en is never high while full=1, so the arbiter never causes overflow.
REQ-018 OWN to STALL when full=1 and owner req=1; STALL to OWN when full=0.
REQ-019 STALL: gnt is held, the burst counter is frozen, and wr_en=0.
REQ-020 Burst counter, width $clog2(MAX_BURST+1):
  - clears on grant;
  - increments on each accepted beat.
REQ-021 Release, in OWN or STALL: owner req=0, or an accepted beat that makes the count equal MAX_BURST.
  - Next cycle: IDLE, gnt=0, last_owner = released index.
REQ-022 Exactly one IDLE bubble cycle between consecutive grants.
REQ-023 A release beat is still written, with wr_en=1 in that cycle.
REQ-024 A requester dropping req in STALL releases ownership with no write.
REQ-025 data_out is 0 when no beat is accepted.

Reset
REQ-026 rst=1 sets the following at the next edge:
  - state=IDLE, gnt=0, burst count=0;
  - last_owner=NUM_REQ-1, so requester 0 has first priority.
REQ-027 While rst=1: wr_en=0, data_out=0, busy=0.
REQ-028 Reset mid-burst discards ownership with no further write.

Configuration
REQ-029 With macro FIFO_ARB_STATS_EN defined, add output stall_cycles (16 bits).
  - Counts cycles spent in STALL, saturating at 16'hFFFF.
  - Cleared by rst.
REQ-030 Without FIFO_ARB_STATS_EN: port and counter are absent; all other behaviour is identical.

Structure
REQ-031 Shared package fifo_arb_pkg holds:
  - the state enum typedef (IDLE/OWN/STALL);
  - default constants for NUM_REQ, DATA_WIDTH, MAX_BURST.
REQ-032 One combinational sub-module, rr_picker: inputs req vector and last_owner; outputs a one-hot winner and a valid flag.

Verification (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=16)
REQ-033 After reset, req=4'b1111 held and full=0:
  - grants go 0,1,2,3,0;
  - 4 writes each;
  - one bubble cycle between grants.
REQ-034 req=4'b0100, data 16'hA5A5, full raised after 2 beats for 3 cycles:
  - STALL for 3 cycles with wr_en=0 and gnt=4'b0100;
  - 2 more writes after full falls, then release.
REQ-035 req[1] drops after 1 beat while req[3]=1:
  - next cycle IDLE;
  - following cycle gnt=4'b1000.
REQ-036 rst pulsed while gnt=4'b0010 at beat 2:
  - next cycle gnt=0, wr_en=0;
  - with req=4'b1111, the first grant is 4'b0001.
REQ-037 full=1 held for 70000 cycles with owner req high:
  - with FIFO_ARB_STATS_EN, stall_cycles saturates at 16'hFFFF;
  - wr_en stays 0 throughout.
REQ-038 Concurrent checks on every cycle:
  - wr_en never high while full=1;
  - gnt always one-hot or zero;
  - no more than 4 writes per grant.
